// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract back end:
// state encoding, format widths and the IEEE-754 single-precision packer.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FP_BIAS = 127;
    localparam int EXP_MAX = 255;
    localparam int MANT_W  = 23;
    localparam int EXP_W   = 8;
    localparam int IEXP_W  = 10;

    function automatic logic [31:0] pack_fp(input logic sign,
                                            input logic [EXP_W-1:0] exp,
                                            input logic [MANT_W-1:0] frac);
        return {sign, exp, frac};
    endfunction

    function automatic logic [31:0] pack_inf(input logic sign);
        return {sign, 8'hFF, 23'h000000};
    endfunction

endpackage

// File: rtl/tc25.sv
// 25-bit two's-complement negation shared by the operand and result converters.
module tc25 (
    input  logic [24:0] a,
    output logic [24:0] y
);

    assign y = (~a) + 25'd1;

endmodule

// File: rtl/fp_norm_pack.sv
// Converts a two's-complement mantissa sum to sign-magnitude, normalises it
// one bit per cycle and packs a single-precision word behind valid/ready.
module fp_norm_pack
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] sum,
    input  logic [7:0]  exp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf
);

    state_t      state_r;
    logic        sign_r;
    logic [24:0] mag_r;
    logic [9:0]  exp_r;

    logic [24:0] neg_s;
    logic [24:0] mag_in_s;
    logic [9:0]  exp_inc_s;
    logic [9:0]  exp_dec_s;

    tc25 u_tc25 (
        .a (sum),
        .y (neg_s)
    );

    // -2^24 negates to itself, which reads correctly as an unsigned 2^24.
    assign mag_in_s  = sum[24] ? neg_s : sum;
    assign exp_inc_s = exp_r + 10'd1;
    assign exp_dec_s = exp_r - 10'd1;

    // Control FSM; every output is registered and updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= 32'h0000_0000;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            sign_r    <= 1'b0;
            mag_r     <= 25'd0;
            exp_r     <= 10'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        sign_r   <= sum[24];
                        mag_r    <= mag_in_s;
                        exp_r    <= {2'b00, exp_in};
                        in_ready <= 1'b0;
                        state_r  <= NORM;
                    end
                end
                NORM: begin
                    if (mag_r == 25'd0) begin
                        result    <= 32'h0000_0000;
                        ovf       <= 1'b0;
                        unf       <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else if (mag_r[24]) begin
                        // Carry out of the adder: one right shift always restores bit 23.
                        mag_r     <= mag_r >> 1;
                        exp_r     <= exp_inc_s;
                        unf       <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                        if (exp_inc_s >= 10'd255) begin
                            result <= pack_inf(sign_r);
                            ovf    <= 1'b1;
                        end else begin
                            result <= pack_fp(sign_r, exp_inc_s[7:0], mag_r[23:1]);
                            ovf    <= 1'b0;
                        end
                    end else if (mag_r[23]) begin
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                        if (exp_r >= 10'd255) begin
                            result <= pack_inf(sign_r);
                            ovf    <= 1'b1;
                            unf    <= 1'b0;
                        end else if (exp_r == 10'd0) begin
                            result <= pack_fp(sign_r, 8'h00, 23'h000000);
                            ovf    <= 1'b0;
                            unf    <= 1'b1;
                        end else begin
                            result <= pack_fp(sign_r, exp_r[7:0], mag_r[22:0]);
                            ovf    <= 1'b0;
                            unf    <= 1'b0;
                        end
                    end else if (exp_r <= 10'd1) begin
                        result    <= pack_fp(sign_r, 8'h00, 23'h000000);
                        ovf       <= 1'b0;
                        unf       <= 1'b1;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        mag_r <= mag_r << 1;
                        exp_r <= exp_dec_s;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Directed-vector bench for fp_norm_pack: results, flags, latency,
// backpressure and reset abort against hand-computed values.
module tb_fp_norm_pack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] sum;
    logic [7:0]  exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        unf;

    int n_checks;
    int n_fail;

    fp_norm_pack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    typedef struct {
        string       tag;
        logic [24:0] s;
        logic [7:0]  e;
        logic [31:0] res;
        logic        o;
        logic        u;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    // Waits for in_ready, issues one operation and returns the cycle count to out_valid.
    task automatic issue(input logic [24:0] s, input logic [7:0] e, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_val("in_ready_wait", {31'd0, in_ready}, 32'd1);
        sum      = s;
        exp_in   = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.s, v.e, lat);
        check_val({v.tag, "_lat"}, lat, v.lat);
        check_val({v.tag, "_res"}, result, v.res);
        check_val({v.tag, "_ovf"}, {31'd0, ovf}, {31'd0, v.o});
        check_val({v.tag, "_unf"}, {31'd0, unf}, {31'd0, v.u});
        check_val({v.tag, "_rdy_done"}, {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check_val({v.tag, "_xfer"}, {31'd0, out_valid}, 32'd0);
        check_val({v.tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int   lat;
        logic [31:0] held;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        sum       = 25'd0;
        exp_in    = 8'd0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_result", result, 32'h0000_0000);
        check_val("rst_ovf", {31'd0, ovf}, 32'd0);
        check_val("rst_unf", {31'd0, unf}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("rel_in_ready", {31'd0, in_ready}, 32'd1);

        vecs.push_back('{"norm_pos",  25'h0800000, 8'd130, 32'h4100_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{"neg_one",   25'h1800000, 8'd127, 32'hBF80_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{"rshift",    25'h1000000, 8'd127, 32'hC000_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{"maxshift",  25'h0000001, 8'd150, 32'h3F80_0000, 1'b0, 1'b0, 25});
        vecs.push_back('{"neg_min",   25'h1FFFFFF, 8'd150, 32'hBF80_0000, 1'b0, 1'b0, 25});
        vecs.push_back('{"zero",      25'h0000000, 8'd77,  32'h0000_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{"unf_shift", 25'h0000001, 8'd10,  32'h0000_0000, 1'b0, 1'b1, 11});
        vecs.push_back('{"ovf_rsh",   25'h1000000, 8'd254, 32'hFF80_0000, 1'b1, 1'b0, 2});
        vecs.push_back('{"ovf_norm",  25'h0800000, 8'd255, 32'h7F80_0000, 1'b1, 1'b0, 2});
        vecs.push_back('{"unf_exp0",  25'h1800000, 8'd0,   32'h8000_0000, 1'b0, 1'b1, 2});
        vecs.push_back('{"frac_bits", 25'h0C00001, 8'd127, 32'h3FC0_0001, 1'b0, 1'b0, 2});
        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result must hold and new requests must be ignored.
        out_ready = 1'b0;
        issue(25'h0800000, 8'd130, lat);
        check_val("bp_lat", lat, 2);
        held = result;
        check_val("bp_res", held, 32'h4100_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sum      = 25'h1800000;
            exp_in   = 8'd127;
            @(posedge clk);
            #1;
            check_val("bp_hold_res", result, 32'h4100_0000);
            check_val("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check_val("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_xfer_valid", {31'd0, out_valid}, 32'd0);
        check_val("bp_xfer_rdy", {31'd0, in_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check_val("bp_no_reaccept", {31'd0, out_valid}, 32'd0);

        // Reset in NORM aborts the long-shift operation.
        @(negedge clk);
        sum      = 25'h0000001;
        exp_in   = 8'd150;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_valid", {31'd0, out_valid}, 32'd0);
        check_val("abort_res", result, 32'h0000_0000);
        check_val("abort_rdy_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_rdy", {31'd0, in_ready}, 32'd1);
        repeat (30) @(posedge clk);
        #1;
        check_val("abort_discard", {31'd0, out_valid}, 32'd0);
        run_vec('{"post_rst", 25'h0800000, 8'd127, 32'h3F80_0000, 1'b0, 1'b0, 2});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_norm_pack.md
# fp_norm_pack

Sequential back end of the floating-point add/subtract datapath: consumes the 25-bit two's-complement mantissa sum and biased exponent produced upstream, converts the sum back to sign-magnitude, normalises it one bit per cycle, and packs an IEEE-754 single-precision word. It is the inverse of the two's-complement conversion applied to operands before the mantissa adder, and it hands the packed result downstream over a valid/ready handshake.

## Interface
- Parameters: none. Widths are fixed by the single-precision format.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `sum`/`exp_in` are valid.
- `in_ready` out 1: block is idle and can accept.
- `sum` in 25: two's-complement mantissa sum; hidden-bit position is bit 23.
- `exp_in` in 8: biased exponent associated with `sum` before normalisation.
- `out_valid` out 1: `result`/flags are valid.
- `out_ready` in 1: downstream accepts the result.
- `result` out 32: packed as {sign, exp[7:0], frac[22:0]}.
- `ovf` out 1: result saturated to infinity.
- `unf` out 1: result flushed to zero.

## Operation
- States: IDLE, NORM, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture `sign`=sum[24] and `mag`=(sign ? two's complement of sum : sum) as a 25-bit unsigned value. −2^24 yields `mag`=2^24.
  - Capture `exp`={2'b00,exp_in} as a 10-bit signed value, then go to NORM.
- NORM: exactly one action per cycle, evaluated in this order:
  1. `mag`==0: result +0 (sign forced 0), go to DONE.
  2. `mag[24]`: shift `mag` right 1 (LSB truncated) and increment `exp`. If the new `exp` ≥255, result ±infinity (frac 0) with `ovf`=1. Go to DONE.
  3. `mag[23]`:
     - `exp`≥255: ±infinity, `ovf`=1.
     - `exp`==0: signed zero, `unf`=1.
     - otherwise: normal result.
     - Go to DONE.
  4. Otherwise, if `exp`≤1: signed zero, `unf`=1, go to DONE. Else shift `mag` left 1, decrement `exp`, stay in NORM.
- DONE:
  - `out_valid`=1; `result`, `ovf` and `unf` are held stable.
  - Go to IDLE on `out_ready`.
  - `in_valid` is ignored outside IDLE.
- Rounding: truncation only. Denormals are not produced.
- The frac field is `mag[22:0]` after normalisation.

## Timing
- Reset:
  - state IDLE.
  - `out_valid`=0; `result`=32'h0; `ovf`=`unf`=0.
  - `in_ready`=0 while `rst` is high, 1 the cycle after release.
- `rst` asserted in NORM or DONE aborts the operation. The pending result is discarded and never presented.
- Latency: with k = left shifts performed, `out_valid` first rises k+2 cycles after the accept cycle. Examples:
  - zero, right-shift, or already-normalised input: 2 cycles.
  - `mag`=1 with sufficient exponent: 25 cycles, the maximum.
- Throughput: one operation per k+3 cycles when `out_ready` is held high.
- Handshake:
  - Accept occurs when `in_valid`&&`in_ready`.
  - Transfer occurs when `out_valid`&&`out_ready`.
  - `in_ready` is 0 in the DONE→IDLE transfer cycle, so there is no same-cycle re-accept.

## Structure
- Shared package `fp_pkg`: state enum (IDLE/NORM/DONE), `FP_BIAS`=127, `EXP_MAX`=255, `MANT_W`=23, `EXP_W`=8, internal exponent width 10.
- Sub-module: one instance of the existing 25-bit two's-complement negation block (`tc25`) for the magnitude conversion.
- Exponent increment/decrement uses plain 10-bit arithmetic in the FSM.

## Test plan
- Normalised positive input: `sum`=25'h0800000, `exp_in`=130 → `result`=32'h41000000, `ovf`=`unf`=0, `out_valid` 2 cycles after accept.
- Negative input and right shift:
  - `sum`=25'h1800000, `exp_in`=127 → 32'hBF800000.
  - `sum`=25'h1000000, `exp_in`=127 → 32'hC0000000.
- Maximum left shift: `sum`=25'h0000001, `exp_in`=150 → 32'h3F800000, `out_valid` 25 cycles after accept.
- Zero, underflow and overflow:
  - `sum`=0 → 32'h00000000 after 2 cycles.
  - `sum`=1, `exp_in`=10 → 32'h00000000 with `unf`=1, after 11 cycles.
  - `sum`=25'h1000000, `exp_in`=254 → 32'hFF800000 with `ovf`=1.
- Backpressure:
  - `out_ready`=0 for 5 cycles in DONE → `result` stable, `in_ready`=0, new `in_valid` ignored.
  - Then `out_ready`=1 → transfer, and IDLE the next cycle.
- Reset during operation: `rst` pulsed during NORM of the `sum`=1 case → next cycle `out_valid`=0 and `result`=0, then `in_ready`=1. A following `sum`=25'h0800000, `exp_in`=127 yields 32'h3F800000.
